// File: rtl/operand_loader.sv
// Operand loader: debounced load button steps a 4-state FSM that captures two
// operands and an opcode for the ALU; a synchronized clear button wipes everything.
module operand_loader #(
    parameter int N        = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] switches,
    input  logic [1:0]   opSwitches,
    input  logic         loadBtn,
    input  logic         clearBtn,
    output logic [N-1:0] firstNum,
    output logic [N-1:0] secNum,
    output logic [1:0]   operation,
    output logic         valid,
    output logic [1:0]   stateCode
);

    // state   | meaning
    // LOAD_A  | waiting for press to capture first operand
    // LOAD_B  | waiting for press to capture second operand
    // LOAD_OP | waiting for press to capture opcode
    // READY   | all values loaded, valid high; next press restarts entry
    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        READY   = 2'b11
    } state_t;

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          load_sync1_q, load_sync1_d;
    logic          load_sync2_q, load_sync2_d;
    logic          clear_sync1_q, clear_sync1_d;
    logic          clear_sync2_q, clear_sync2_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic          deb_level_q, deb_level_d;
    logic          press_pulse_q, press_pulse_d;
    state_t        state_q, state_d;
    logic [N-1:0]  first_num_q, first_num_d;
    logic [N-1:0]  sec_num_q, sec_num_d;
    logic [1:0]    operation_q, operation_d;

    always_comb begin
        load_sync1_d  = loadBtn;
        load_sync2_d  = load_sync1_q;
        clear_sync1_d = clearBtn;
        clear_sync2_d = clear_sync1_q;
    end

    // Level flips on the edge where the mismatch run would reach DEBOUNCE.
    always_comb begin
        deb_cnt_d   = '0;
        deb_level_d = deb_level_q;
        if (load_sync2_q != deb_level_q) begin
            if (deb_cnt_q == CW'(DEBOUNCE - 1)) begin
                deb_level_d = load_sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + CW'(1);
            end
        end
        press_pulse_d = deb_level_d & ~deb_level_q;
    end

    always_comb begin
        state_d     = state_q;
        first_num_d = first_num_q;
        sec_num_d   = sec_num_q;
        operation_d = operation_q;
        if (clear_sync2_q) begin
            state_d     = LOAD_A;
            first_num_d = '0;
            sec_num_d   = '0;
            operation_d = '0;
        end else if (press_pulse_q) begin
            case (state_q)
                LOAD_A: begin
                    first_num_d = switches;
                    state_d     = LOAD_B;
                end
                LOAD_B: begin
                    sec_num_d = switches;
                    state_d   = LOAD_OP;
                end
                LOAD_OP: begin
                    operation_d = opSwitches;
                    state_d     = READY;
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_sync1_q  <= 1'b0;
            load_sync2_q  <= 1'b0;
            clear_sync1_q <= 1'b0;
            clear_sync2_q <= 1'b0;
            deb_cnt_q     <= '0;
            deb_level_q   <= 1'b0;
            press_pulse_q <= 1'b0;
            state_q       <= LOAD_A;
            first_num_q   <= '0;
            sec_num_q     <= '0;
            operation_q   <= '0;
        end else begin
            load_sync1_q  <= load_sync1_d;
            load_sync2_q  <= load_sync2_d;
            clear_sync1_q <= clear_sync1_d;
            clear_sync2_q <= clear_sync2_d;
            deb_cnt_q     <= deb_cnt_d;
            deb_level_q   <= deb_level_d;
            press_pulse_q <= press_pulse_d;
            state_q       <= state_d;
            first_num_q   <= first_num_d;
            sec_num_q     <= sec_num_d;
            operation_q   <= operation_d;
        end
    end

    assign firstNum  = first_num_q;
    assign secNum    = sec_num_q;
    assign operation = operation_q;
    assign stateCode = state_q;
    assign valid     = (state_q == READY);

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a history-based reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_operand_loader;

    localparam int N   = 4;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] switches;
    logic [1:0]   opSwitches;
    logic         loadBtn;
    logic         clearBtn;
    logic [N-1:0] firstNum;
    logic [N-1:0] secNum;
    logic [1:0]   operation;
    logic         valid;
    logic [1:0]   stateCode;

    int checks   = 0;
    int failures = 0;

    operand_loader #(.N(N), .DEBOUNCE(DEB)) dut (
        .clk        (clk),
        .rst        (rst),
        .switches   (switches),
        .opSwitches (opSwitches),
        .loadBtn    (loadBtn),
        .clearBtn   (clearBtn),
        .firstNum   (firstNum),
        .secNum     (secNum),
        .operation  (operation),
        .valid      (valid),
        .stateCode  (stateCode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: raw button samples per edge since reset; the
    // synchronized value seen at edge e is the raw sample from edge e-2.
    logic         ld_hist [0:8191];
    logic         cl_hist [0:8191];
    int           ec      = 0;
    logic         m_deb   = 1'b0;
    logic         m_pulse = 1'b0;
    int           m_state = 0;
    logic [N-1:0] m_a     = '0;
    logic [N-1:0] m_b     = '0;
    logic [1:0]   m_op    = '0;
    logic         m_all_diff, m_old_pulse, m_new_deb, m_clr, m_v;
    int           m_idx;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ec = 0; m_deb = 1'b0; m_pulse = 1'b0; m_state = 0;
            m_a = '0; m_b = '0; m_op = '0;
        end else begin
            ld_hist[ec] = loadBtn;
            cl_hist[ec] = clearBtn;
            m_all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                m_idx = ec - 2 - j;
                m_v   = (m_idx >= 0) ? ld_hist[m_idx] : 1'b0;
                if (m_v == m_deb) m_all_diff = 1'b0;
            end
            m_clr       = (ec >= 2) ? cl_hist[ec-2] : 1'b0;
            m_old_pulse = m_pulse;
            m_new_deb   = m_all_diff ? ~m_deb : m_deb;
            m_pulse     = m_new_deb & ~m_deb;
            m_deb       = m_new_deb;
            if (m_clr) begin
                m_state = 0; m_a = '0; m_b = '0; m_op = '0;
            end else if (m_old_pulse) begin
                case (m_state)
                    0: begin m_a  = switches;   m_state = 1; end
                    1: begin m_b  = switches;   m_state = 2; end
                    2: begin m_op = opSwitches; m_state = 3; end
                    default: m_state = 0;
                endcase
            end
            ec++;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("model_firstNum",  int'(firstNum),  int'(m_a));
            check("model_secNum",    int'(secNum),    int'(m_b));
            check("model_operation", int'(operation), int'(m_op));
            check("model_stateCode", int'(stateCode), m_state);
            check("model_valid",     int'(valid),     (m_state == 3) ? 1 : 0);
        end
    end

    // Press, measure edges from first high sample to the state change, hold, release.
    task automatic press(input logic [N-1:0] sw, input logic [1:0] op, input int hold,
                         input string nm);
        int n;
        logic [1:0] s0;
        @(negedge clk);
        switches = sw; opSwitches = op; loadBtn = 1'b1;
        s0 = stateCode;
        @(posedge clk);
        #1;
        n = 0;
        while (stateCode == s0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(nm, n, 2 + DEB);
        repeat (hold) @(negedge clk);
        loadBtn = 1'b0;
        switches = ~sw;
        opSwitches = ~op;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; switches = '0; opSwitches = '0; loadBtn = 1'b0; clearBtn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_firstNum",  int'(firstNum),  0);
        check("reset_secNum",    int'(secNum),    0);
        check("reset_operation", int'(operation), 0);
        check("reset_valid",     int'(valid),     0);
        check("reset_stateCode", int'(stateCode), 0);

        switches = 4'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); loadBtn = 1'b1;
            @(negedge clk);
            @(negedge clk); loadBtn = 1'b0;
            @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check("bounce_stateCode", int'(stateCode), 0);
        check("bounce_firstNum",  int'(firstNum),  0);
        check("bounce_secNum",    int'(secNum),    0);

        press(4'd3, 2'b00, 94, "held_capture_edges");
        check("held_stateCode", int'(stateCode), 1);
        check("held_firstNum",  int'(firstNum),  3);

        press(4'd5, 2'b00, 3, "b_capture_edges");
        press(4'd0, 2'b01, 3, "op_capture_edges");
        check("full_firstNum",  int'(firstNum),  3);
        check("full_secNum",    int'(secNum),    5);
        check("full_operation", int'(operation), 1);
        check("full_valid",     int'(valid),     1);
        check("full_stateCode", int'(stateCode), 3);

        press(4'd12, 2'b10, 3, "ready_press_edges");
        check("ready_valid",     int'(valid),     0);
        check("ready_stateCode", int'(stateCode), 0);
        check("ready_firstNum",  int'(firstNum),  3);
        check("ready_secNum",    int'(secNum),    5);
        check("ready_operation", int'(operation), 1);

        press(4'd7, 2'b00, 3, "clr_a_edges");
        press(4'd2, 2'b00, 3, "clr_b_edges");
        @(negedge clk);
        opSwitches = 2'b10; loadBtn = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clearBtn = 1'b1;
        repeat (6) @(negedge clk);
        clearBtn = 1'b0;
        #1;
        check("clear_stateCode", int'(stateCode), 0);
        check("clear_operation", int'(operation), 0);
        check("clear_firstNum",  int'(firstNum),  0);
        check("clear_secNum",    int'(secNum),    0);
        check("clear_valid",     int'(valid),     0);
        loadBtn = 1'b0;
        repeat (12) @(negedge clk);
        check("clear_after_stateCode", int'(stateCode), 0);

        press(4'd4, 2'b00, 3, "op11_a_edges");
        press(4'd6, 2'b00, 3, "op11_b_edges");
        press(4'd0, 2'b11, 3, "op11_op_edges");
        check("op11_operation", int'(operation), 3);
        check("op11_valid",     int'(valid),     1);

        press(4'd0, 2'b00, 3, "restart_edges");
        press(4'd10, 2'b00, 3, "rst_a_edges");
        press(4'd12, 2'b00, 3, "rst_b_edges");
        check("pre_rst_stateCode", int'(stateCode), 2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_firstNum",  int'(firstNum),  0);
        check("async_secNum",    int'(secNum),    0);
        check("async_operation", int'(operation), 0);
        check("async_valid",     int'(valid),     0);
        check("async_stateCode", int'(stateCode), 0);
        #10;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        press(4'd9, 2'b00, 3, "post_rst_edges");
        check("post_rst_firstNum",  int'(firstNum),  9);
        check("post_rst_stateCode", int'(stateCode), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits.
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, giving the number of stable synchronized cycles needed to accept a button level change; legal range is 2 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port switches, input, N bits: operand value from board switches.
REQ-006 The block SHALL have port opSwitches, input, 2 bits: operation code from board switches.
REQ-007 The block SHALL have port loadBtn, input, 1 bit: raw, asynchronous, bouncing load pushbutton, active-high.
REQ-008 The block SHALL have port clearBtn, input, 1 bit: raw, asynchronous clear pushbutton, active-high.
REQ-009 The block SHALL have port firstNum, output, N bits: registered first operand to the ALU.
REQ-010 The block SHALL have port secNum, output, N bits: registered second operand to the ALU.
REQ-011 The block SHALL have port operation, output, 2 bits: registered operation code to the ALU.
REQ-012 The block SHALL have port valid, output, 1 bit: high when all three values are loaded and stable.
REQ-013 The block SHALL have port stateCode, output, 2 bits: current FSM state, for LEDs.

Function
REQ-014 loadBtn and clearBtn SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 The synchronized loadBtn SHALL feed a debouncer that works as follows:
- A counter increments every cycle while the synchronized level differs from the debounced level.
- The counter clears whenever the two levels are equal.
- The debounced level takes the synchronized value on the edge at which the counter reaches DEBOUNCE.
REQ-016 A rising edge of the debounced level SHALL produce a registered pressPulse that is high for exactly one cycle; a held button produces only one pulse.
REQ-017 Timing of a press SHALL be as follows, where k is the first edge that samples raw loadBtn high and the input is held stable:
- The debounced level rises at edge k+1+DEBOUNCE.
- pressPulse is high during the following cycle.
- The capture occurs at edge k+2+DEBOUNCE.
REQ-018 A glitch of loadBtn shorter than DEBOUNCE synchronized cycles SHALL produce no pulse.
REQ-019 The FSM SHALL have four states with these stateCode values: LOAD_A=00, LOAD_B=01, LOAD_OP=10, READY=11.
REQ-020 In LOAD_A, a pulse SHALL capture switches into firstNum and move the FSM to LOAD_B.
REQ-021 In LOAD_B, a pulse SHALL capture switches into secNum and move the FSM to LOAD_OP.
REQ-022 In LOAD_OP, a pulse SHALL capture opSwitches into operation, move the FSM to READY, and set valid high on the same edge.
REQ-023 In READY, a pulse SHALL clear valid and move the FSM to LOAD_A; firstNum, secNum and operation keep their old values until overwritten.
REQ-024 Without a pulse, the FSM state and all outputs SHALL hold; switch changes outside a capture edge have no effect.
REQ-025 operation=11 SHALL be accepted unchanged; the block does not check opcode legality.
REQ-026 While the synchronized clearBtn is high, each edge SHALL do all of the following:
- Force state to LOAD_A.
- Zero firstNum, secNum and operation.
- Clear valid.
REQ-027 If a clear and a pulse coincide on the same edge, clear SHALL take priority and the pulse is discarded.
REQ-028 valid SHALL be high only in READY; valid equals (stateCode==11) at all times.

Reset
REQ-029 When rst is low, the block SHALL immediately, without waiting for a clock, set firstNum=0, secNum=0, operation=00, valid=0 and stateCode=00, and clear the synchronizers, debouncer counter, debounced level and pressPulse.
REQ-030 Reset asserted in the middle of an operation (any state, or mid-debounce) SHALL discard partial entries; after rst goes high, the next accepted press captures firstNum.

Verification
REQ-031 The bench SHALL cover a full load with DEBOUNCE=4:
- Stimulus: press with switches=3, then switches=5, then opSwitches=01.
- Response: firstNum=3, secNum=5, operation=01, valid=1 and stateCode=11.
- Each capture lands exactly 6 edges after the first high sample.
REQ-032 The bench SHALL cover bounce rejection: loadBtn toggling every 2 cycles for 20 cycles and then released -> no pulse, state stays LOAD_A, and outputs stay at 0.
REQ-033 The bench SHALL cover a held button: loadBtn held high for 100 cycles in LOAD_A -> exactly one capture, and state becomes LOAD_B.
REQ-034 The bench SHALL cover a press in READY: press -> valid drops to 0, stateCode=00, and firstNum=3, secNum=5, operation=01 are retained.
REQ-035 The bench SHALL cover clear priority: a pulse in LOAD_OP coinciding with synchronized clearBtn high -> operation=00, all operands 0, valid=0 and stateCode=00.
REQ-036 The bench SHALL cover asynchronous reset: rst driven low between clock edges while in LOAD_OP -> outputs are 0 before the next edge, and after release a press with switches=9 gives firstNum=9.
